// File: rtl/stopwatch_pkg.sv
// Shared types for the stopwatch controller: FSM state encoding and the
// digit-range helper used by the top level and the digit counters.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Largest legal value of a W-bit digit counting modulo mod.
  function automatic logic [31:0] digit_max(input int mod);
    return 32'(mod - 1);
  endfunction

endpackage

// File: rtl/mod_digit.sv
// One modulo-MOD decimal-style digit counter; advances on en and carries
// out in the same cycle it wraps from MOD-1 back to 0.
module mod_digit
  import stopwatch_pkg::*;
#(
  parameter int MOD = 11,
  parameter int W   = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en_i,
  input  logic         clr_i,
  output logic [W-1:0] q_o,
  output logic         carry_o
);

  localparam logic [W-1:0] MAX_Q = W'(digit_max(MOD));

  logic [W-1:0] q_q;
  logic         at_max;

  assign at_max  = (q_q == MAX_Q);
  assign carry_o = en_i && at_max;
  assign q_o     = q_q;

  // NOTE: sequential state is written with <= only, so every register samples
  // the pre-edge values of its neighbours regardless of block ordering.
  always_ff @(posedge clk) begin
    if (!reset) begin
      q_q <= '0;
    end else if (clr_i) begin
      q_q <= '0;
    end else if (en_i) begin
      q_q <= at_max ? '0 : q_q + 1'b1;
    end
  end

endmodule

// File: rtl/stopwatch_ctrl.sv
// Run/pause/clear stopwatch: prescaler-driven tick into a ripple chain of
// modulo digits, with a target compare that parks the FSM in DONE.
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int PRESCALE = 4,
  parameter int MOD      = 11,
  parameter int DIGITS   = 2,
  parameter int W        = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                stop,
  input  logic                clear,
  input  logic [DIGITS*W-1:0] target,
  output logic [DIGITS*W-1:0] count,
  output logic                running,
  output logic                done,
  output logic [1:0]          state
);

  localparam int            PW      = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRE_TOP = PW'(PRESCALE - 1);
  localparam logic [W-1:0]  MAX_Q   = W'(digit_max(MOD));

  state_t        state_q;
  logic [PW-1:0] presc_q;
  logic          done_q;

  logic              target_ok;
  logic              match;
  logic              advance;
  logic              presc_wrap;
  logic              tick;
  logic              digit_clr;
  logic [DIGITS-1:0] digit_en;
  logic [DIGITS-1:0] digit_carry;

  // A target with any digit outside 0..MOD-1, or all zero, can never be hit.
  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    target_ok = (target != '0);
    for (int i = 0; i < DIGITS; i++) begin
      if (target[i*W +: W] > MAX_Q) target_ok = 1'b0;
    end
  end

  assign match      = target_ok && (count == target);
  assign presc_wrap = (presc_q == PRE_TOP);

  // The run clock keeps going on a stop cycle; only clear or a match that
  // is about to take the FSM into DONE freezes it, so count holds in DONE.
  assign advance   = (state_q == RUN) && !clear && !(match && !stop);
  assign tick      = advance && presc_wrap;
  assign digit_clr = clear || ((state_q == DONE) && start);

  always_comb begin
    digit_en    = '0;
    digit_en[0] = tick;
    for (int i = 1; i < DIGITS; i++) begin
      digit_en[i] = digit_carry[i-1];
    end
  end

  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    mod_digit #(
      .MOD (MOD),
      .W   (W)
    ) u_digit (
      .clk     (clk),
      .reset   (reset),
      .en_i    (digit_en[g]),
      .clr_i   (digit_clr),
      .q_o     (count[g*W +: W]),
      .carry_o (digit_carry[g])
    );
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      presc_q <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (advance) presc_q <= presc_wrap ? '0 : presc_q + 1'b1;
      if (clear) begin
        state_q <= IDLE;
        presc_q <= '0;
      end else begin
        unique case (state_q)
          IDLE: begin
            if (start) begin
              state_q <= RUN;
              presc_q <= '0;
            end
          end
          RUN: begin
            if (stop) begin
              state_q <= PAUSE;
            end else if (match) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end
          end
          PAUSE: begin
            if (start && !stop) state_q <= RUN;
          end
          DONE: begin
            if (start) begin
              state_q <= RUN;
              presc_q <= '0;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign state   = state_q;
  assign running = (state_q == RUN);
  assign done    = done_q;

endmodule
